wb_shared_bus_arbiter: RTL

Registered N-master to 1-slave Wishbone (pipelined) arbiter with round-robin fairness, cycle-level grant locking and an optional bus-timeout watchdog. It sits in front of the instruction/data bus muxes and shares one slave-side bus among CPU instruction port, CPU data port and DMA-class masters. It replaces the fixed-priority 2-port arbitration with fair, lockable grants that are safe against hangs.

---
 rtl/wb_shared_bus_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wb_shared_bus_arbiter.sv
// rtl/wb_shared_bus_arbiter.sv - round-robin N:1 pipelined Wishbone arbiter with cycle-level grant locking
// Optional bus-timeout watchdog compiled in by defining WB_ARB_TIMEOUT_EN.
module wb_shared_bus_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_w,
    input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic [NUM_MASTERS-1:0]             m_stall,
    output logic [DATA_WIDTH-1:0]              m_dat_r,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [ADDR_WIDTH-1:0]              s_adr,
    output logic [DATA_WIDTH-1:0]              s_dat_w,
    output logic [SELECT_WIDTH-1:0]            s_sel,
    input  logic                               s_ack,
    input  logic                               s_err,
    input  logic                               s_stall,
    input  logic [DATA_WIDTH-1:0]              s_dat_r,
    output logic [NUM_MASTERS-1:0]             grant
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    typedef logic [IDX_W-1:0] idx_t;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
    localparam logic [7:0] TIMER_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] timer_q, timer_d;
`else
    typedef enum logic {IDLE, BUSY} state_t;
`endif

    state_t     state_q, state_d;
    idx_t       owner_q, owner_d;   // current owner in BUSY/ABORT, previous owner while IDLE
    logic [3:0] outst_q, outst_d;
    logic       found;
    idx_t       pick;
    logic       accept;
    logic       resp;

    always_comb begin : rr_pick
        idx_t cand;
        cand  = '0;
        found = 1'b0;
        pick  = owner_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = idx_t'((int'(owner_q) + k) % NUM_MASTERS);
            if (!found && m_cyc[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin : bus_mux
        grant   = '0;
        m_ack   = '0;
        m_err   = '0;
        m_stall = '1;
        m_dat_r = '0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        accept  = 1'b0;
        resp    = 1'b0;
        if (state_q == BUSY) begin
            grant[owner_q]   = 1'b1;
            s_cyc            = m_cyc[owner_q];
            s_stb            = m_stb[owner_q];
            s_we             = m_we[owner_q];
            s_adr            = m_adr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_dat_w          = m_dat_w[owner_q*DATA_WIDTH +: DATA_WIDTH];
            s_sel            = m_sel[owner_q*SELECT_WIDTH +: SELECT_WIDTH];
            m_ack[owner_q]   = s_ack;
            m_err[owner_q]   = s_err;
            m_stall[owner_q] = s_stall;
            m_dat_r          = s_dat_r;
            accept           = m_stb[owner_q] & ~s_stall;
            resp             = s_ack | s_err;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (state_q == ABORT) begin
            grant[owner_q] = 1'b1;
            m_err[owner_q] = 1'b1;
        end
`endif
    end

    always_comb begin : next_state
        state_d = state_q;
        owner_d = owner_q;
        outst_d = outst_q;
`ifdef WB_ARB_TIMEOUT_EN
        timer_d = timer_q;
`endif
        case (state_q)
            IDLE: begin
                outst_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
                if (found) begin
                    state_d = BUSY;
                    owner_d = pick;
                end
            end
            BUSY: begin
                if (!m_cyc[owner_q]) begin
                    state_d = IDLE;
                    outst_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
                    timer_d = '0;
`endif
                end else begin
                    if (accept && !resp && outst_q != 4'd15) begin
                        outst_d = outst_q + 4'd1;
                    end else if (resp && !accept && outst_q != 4'd0) begin
                        outst_d = outst_q - 4'd1;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    // Only a slave that owes responses and stays silent is timed out.
                    timer_d = (resp || outst_q == 4'd0) ? 8'd0 : timer_q + 8'd1;
                    if (!resp && timer_q >= TIMER_LIMIT) begin
                        state_d = ABORT;
                    end
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                state_d = IDLE;
                outst_d = '0;
                timer_d = '0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= idx_t'(NUM_MASTERS - 1);
            outst_q <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            outst_q <= outst_d;
`ifdef WB_ARB_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

endmodule
